// File: rtl/register_file_sb.sv
// Register file with per-register pending (scoreboard) bits.
// The zero register and same-cycle bypass are optional.
//
// Parameters : DATA_W (>= 8), ADDR_W (depth = 2**ADDR_W), ZERO_REG (1 = reg 0 reads 0).
// Macro      : REGFILE_BYPASS_EN. When it is defined, a write is visible on the read
//              ports, and clears busyN, in the same cycle.
//
// Ports
//   clk, reset            : single clock; synchronous active-high reset
//   regWrite, write_reg,
//   write_data,
//   byteOperations        : write-back; a byte write updates bits [7:0] only
//   reserve, reserve_reg  : issue-side pending mark
//   read_reg1/2           : read addresses
//   read_data1/2          : combinational read data
//   busy1/2               : pending flag of each read address
//   hazard                : busy1 | busy2
//   busy_count            : registered number of pending registers
module register_file_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              regWrite,
  input  logic [ADDR_W-1:0] write_reg,
  input  logic [DATA_W-1:0] write_data,
  input  logic              byteOperations,
  input  logic              reserve,
  input  logic [ADDR_W-1:0] reserve_reg,
  input  logic [ADDR_W-1:0] read_reg1,
  input  logic [ADDR_W-1:0] read_reg2,
  output logic [DATA_W-1:0] read_data1,
  output logic [DATA_W-1:0] read_data2,
  output logic              busy1,
  output logic              busy2,
  output logic              hazard,
  output logic [ADDR_W:0]   busy_count
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] R0 = '0;

  logic [DATA_W-1:0] regs [DEPTH];
  logic [DEPTH-1:0]  pend;
  logic [DEPTH-1:0]  pend_nx;
  logic [ADDR_W:0]   pop;
  logic              wr_en;
  logic              rsv_en;
  logic [DATA_W-1:0] wr_val;

  function automatic logic is_zero(
    input logic [ADDR_W-1:0] a
  );
    return (ZERO_REG != 0) && (a == R0);
  endfunction

  // Writes and reservations aimed at a hardwired zero
  // register are dropped here, so nothing below has
  // to special-case them.
  assign wr_en  = regWrite && !is_zero(write_reg);
  assign rsv_en = reserve && !is_zero(reserve_reg);

  generate
    if (DATA_W > 8) begin : g_merge
      assign wr_val = byteOperations
        ? {regs[write_reg][DATA_W-1:8], write_data[7:0]}
        : write_data;
    end else begin : g_full
      // When the register is only 8 bits wide, a byte
      // write and a full write are the same operation.
      assign wr_val = write_data;
    end
  endgenerate

  // A write clears the pending bit first, so a reserve
  // in the same cycle wins: a later instruction has
  // already claimed the register again.
  always_comb begin
    pend_nx = pend;
    if (wr_en) pend_nx[write_reg] = 1'b0;
    if (rsv_en) pend_nx[reserve_reg] = 1'b1;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pop = pop + {{ADDR_W{1'b0}}, pend_nx[i]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
      pend       <= '0;
      busy_count <= '0;
    end else begin
      if (wr_en) regs[write_reg] <= wr_val;
      pend       <= pend_nx;
      busy_count <= pop;
    end
  end

  always_comb begin
    read_data1 = regs[read_reg1];
    busy1      = pend[read_reg1];
    if (is_zero(read_reg1)) begin
      read_data1 = '0;
      busy1      = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (!reset && wr_en &&
             write_reg == read_reg1) begin
      read_data1 = wr_val;
      busy1      = busy1 && rsv_en &&
                   (reserve_reg == read_reg1);
    end
`endif
  end

  always_comb begin
    read_data2 = regs[read_reg2];
    busy2      = pend[read_reg2];
    if (is_zero(read_reg2)) begin
      read_data2 = '0;
      busy2      = 1'b0;
    end
`ifdef REGFILE_BYPASS_EN
    else if (!reset && wr_en &&
             write_reg == read_reg2) begin
      read_data2 = wr_val;
      busy2      = busy2 && rsv_en &&
                   (reserve_reg == read_reg2);
    end
`endif
  end

  assign hazard = busy1 | busy2;

endmodule

// File: tb/tb_register_file_sb.sv
// Randomized bench for register_file_sb against an array model.
// Directed scenarios first, then random traffic.
module tb_register_file_sb;

  logic        clk;
  logic        reset;
  logic        regWrite;
  logic [4:0]  write_reg;
  logic [31:0] write_data;
  logic        byteOperations;
  logic        reserve;
  logic [4:0]  reserve_reg;
  logic [4:0]  read_reg1;
  logic [4:0]  read_reg2;
  logic [31:0] read_data1;
  logic [31:0] read_data2;
  logic        busy1;
  logic        busy2;
  logic        hazard;
  logic [5:0]  busy_count;

  register_file_sb dut (
    .clk(clk),
    .reset(reset),
    .regWrite(regWrite),
    .write_reg(write_reg),
    .write_data(write_data),
    .byteOperations(byteOperations),
    .reserve(reserve),
    .reserve_reg(reserve_reg),
    .read_reg1(read_reg1),
    .read_reg2(read_reg2),
    .read_data1(read_data1),
    .read_data2(read_data2),
    .busy1(busy1),
    .busy2(busy2),
    .hazard(hazard),
    .busy_count(busy_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] m_regs [32];
  bit          m_busy [32];
  int          m_cnt;
  bit          armed;
  int          n_chk;
  int          n_pass;
  bit          bypass_on;

  task automatic check(
    input string       tag,
    input logic [63:0] got,
    input logic [63:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  function automatic logic [31:0] exp_rd(
    input logic [4:0] a
  );
    if (a == 5'd0) return 32'd0;
    if (bypass_on && !reset && regWrite &&
        write_reg == a) begin
      if (byteOperations)
        return {m_regs[a][31:8], write_data[7:0]};
      return write_data;
    end
    return m_regs[a];
  endfunction

  function automatic logic exp_busy(
    input logic [4:0] a
  );
    if (a == 5'd0) return 1'b0;
    if (bypass_on && !reset && regWrite &&
        write_reg == a &&
        !(reserve && reserve_reg == a))
      return 1'b0;
    return m_busy[a];
  endfunction

  task automatic drive(
    input bit        rst,
    input bit        we,
    input int        wr,
    input logic [31:0] wd,
    input bit        bo,
    input bit        rs,
    input int        rr,
    input int        r1,
    input int        r2
  );
    reset          = rst;
    regWrite       = we;
    write_reg      = 5'(wr);
    write_data     = wd;
    byteOperations = bo;
    reserve        = rs;
    reserve_reg    = 5'(rr);
    read_reg1      = 5'(r1);
    read_reg2      = 5'(r2);
  endtask

  task automatic settle_check();
    bit eb1;
    bit eb2;
    #2;
    if (armed) begin
      eb1 = exp_busy(read_reg1);
      eb2 = exp_busy(read_reg2);
      check("rd1", read_data1, exp_rd(read_reg1));
      check("rd2", read_data2, exp_rd(read_reg2));
      check("busy1", busy1, eb1);
      check("busy2", busy2, eb2);
      check("hazard", hazard, eb1 | eb2);
      check("count", busy_count, m_cnt);
    end
  endtask

  task automatic edge_update();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        m_regs[i] = 32'd0;
        m_busy[i] = 1'b0;
      end
      armed = 1'b1;
    end else begin
      if (regWrite && write_reg != 5'd0) begin
        if (byteOperations)
          m_regs[write_reg][7:0] = write_data[7:0];
        else
          m_regs[write_reg] = write_data;
        m_busy[write_reg] = 1'b0;
      end
      if (reserve && reserve_reg != 5'd0)
        m_busy[reserve_reg] = 1'b1;
    end
    m_cnt = 0;
    for (int i = 0; i < 32; i++) m_cnt += m_busy[i];
    #1;
  endtask

  task automatic cyc(
    input bit        rst,
    input bit        we,
    input int        wr,
    input logic [31:0] wd,
    input bit        bo,
    input bit        rs,
    input int        rr,
    input int        r1,
    input int        r2
  );
    drive(rst, we, wr, wd, bo, rs, rr, r1, r2);
    settle_check();
    edge_update();
  endtask

  task automatic probe(input int r1, input int r2);
    drive(0, 0, 0, 32'd0, 0, 0, 0, r1, r2);
    #1;
  endtask

  initial begin
    int a;
    int b;
    n_chk  = 0;
    n_pass = 0;
    armed  = 1'b0;
    m_cnt  = 0;
    bypass_on = 1'b0;
`ifdef REGFILE_BYPASS_EN
    bypass_on = 1'b1;
`endif
    drive(1, 0, 0, 32'd0, 0, 0, 0, 0, 1);
    @(posedge clk);
    #1;
    cyc(1, 0, 0, 32'd0, 0, 0, 0, 0, 1);

    probe(0, 1);
    check("rst_rd1", read_data1, 32'd0);
    check("rst_rd2", read_data2, 32'd0);
    check("rst_cnt", busy_count, 6'd0);
    check("rst_haz", hazard, 1'b0);

    cyc(0, 1, 2, 32'h0000_07F8, 0, 0, 0, 0, 0);
    probe(2, 0);
    check("wr_r2", read_data1, 32'h0000_07F8);
    cyc(0, 1, 0, 32'hFFFF_FFFF, 0, 0, 0, 0, 0);
    probe(0, 2);
    check("wr_r0", read_data1, 32'd0);

    cyc(0, 1, 3, 32'h1234_5678, 0, 0, 0, 3, 0);
    cyc(0, 1, 3, 32'h0000_00AB, 1, 0, 0, 3, 0);
    probe(3, 0);
    check("byte_r3", read_data1, 32'h1234_56AB);

    cyc(0, 0, 0, 32'd0, 0, 1, 5, 5, 6);
    cyc(0, 0, 0, 32'd0, 0, 1, 6, 5, 6);
    probe(5, 6);
    check("rsv_cnt", busy_count, 6'd2);
    check("rsv_b1", busy1, 1'b1);
    check("rsv_haz", hazard, 1'b1);
    cyc(0, 1, 5, 32'h55, 0, 0, 0, 5, 6);
    probe(5, 0);
    check("clr_b1", busy1, 1'b0);
    check("clr_cnt", busy_count, 6'd1);
    cyc(0, 1, 6, 32'h66, 0, 1, 6, 6, 0);
    probe(6, 0);
    check("rw_b1", busy1, 1'b1);
    check("rw_cnt", busy_count, 6'd1);
    check("rw_rd", read_data1, 32'h66);
    cyc(0, 0, 0, 32'd0, 0, 1, 0, 0, 0);
    probe(0, 6);
    check("rsv0_cnt", busy_count, 6'd1);

    drive(0, 1, 4, 32'hDEAD_BEEF, 0, 0, 0, 4, 0);
    settle_check();
    check("bypass_rd1", read_data1,
          bypass_on ? 32'hDEAD_BEEF : 32'd0);
    edge_update();
    probe(4, 0);
    check("after_byp", read_data1, 32'hDEAD_BEEF);

    cyc(0, 0, 0, 32'd0, 0, 1, 7, 7, 8);
    cyc(0, 0, 0, 32'd0, 0, 1, 8, 7, 8);
    cyc(1, 1, 7, 32'h7777, 0, 1, 8, 7, 8);
    probe(7, 8);
    check("rstm_rd", read_data1, 32'd0);
    check("rstm_b1", busy1, 1'b0);
    check("rstm_b2", busy2, 1'b0);
    check("rstm_cnt", busy_count, 6'd0);

    for (int n = 0; n < 3000; n++) begin
      a = ($urandom_range(0, 3) == 0)
          ? int'($urandom_range(0, 31))
          : int'($urandom_range(0, 7));
      b = int'($urandom_range(0, 7));
      cyc(($urandom_range(0, 99) == 0),
          $urandom_range(0, 1) == 1, a, $urandom,
          $urandom_range(0, 3) == 0,
          $urandom_range(0, 1) == 1, b,
          ($urandom_range(0, 1) == 1) ? a : b,
          int'($urandom_range(0, 7)));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/register_file_sb.md
REGISTER_FILE_SB -- requirements
Module: register_file_sb

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register data width in bits (minimum 8).
REQ-002 SHALL provide parameter ADDR_W, default 5, register address width; depth = 2**ADDR_W.
REQ-003 SHALL provide parameter ZERO_REG, default 1, register 0 hardwired to zero when 1.
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port regWrite  input  1  write-back enable.
REQ-007 SHALL have port write_reg  input  ADDR_W  write-back destination.
REQ-008 SHALL have port write_data  input  DATA_W  write-back data.
REQ-009 SHALL have port byteOperations  input  1  write-back updates bits [7:0] only.
REQ-010 SHALL have port reserve  input  1  mark a destination pending (issue).
REQ-011 SHALL have port reserve_reg  input  ADDR_W  register to mark pending.
REQ-012 SHALL have ports read_reg1, read_reg2  input  ADDR_W  read addresses.
REQ-013 SHALL have ports read_data1, read_data2  output  DATA_W  read data, combinational.
REQ-014 SHALL have ports busy1, busy2  output  1  pending flag of read_reg1 / read_reg2.
REQ-015 SHALL have port hazard  output  1  busy1 OR busy2.
REQ-016 SHALL have port busy_count  output  ADDR_W+1  number of registers currently pending.

Function
REQ-017 Writes SHALL occur on the rising clk edge when regWrite=1 and reset=0.
REQ-018 byteOperations=1 SHALL update bits [7:0] from write_data[7:0] and preserve bits [DATA_W-1:8]; byteOperations=0 SHALL update all bits.
REQ-019 With ZERO_REG=1, writes and reservations to register 0 SHALL be ignored, and reads of register 0 SHALL return 0 with busy=0.
REQ-020 Reads SHALL be asynchronous: read_dataN equals the stored register addressed by read_regN, zero latency.
REQ-021 Scoreboard: one busy bit per register; reserve=1 SHALL set busy[reserve_reg] at the edge.
REQ-022 regWrite=1 SHALL clear busy[write_reg] at the edge.
REQ-023 reserve and regWrite to the same register in the same cycle: reserve SHALL win (busy ends 1, data written).
REQ-024 reserve of an already-busy register SHALL leave busy=1 with no error and no count change.
REQ-025 regWrite to a non-busy register SHALL write data, leave busy=0 and leave the count unchanged.
REQ-026 busy_count SHALL be a registered count equal to the population of the busy bits after each edge; it SHALL never wrap (max 2**ADDR_W, or 2**ADDR_W-1 with ZERO_REG=1).
REQ-027 busyN SHALL reflect current busy bits combinationally; with bypass enabled, a same-cycle regWrite to read_regN SHALL force busyN=0 unless a same-cycle reserve targets the same register.

Reset
REQ-028 reset=1 at an edge SHALL clear all registers to 0, all busy bits to 0 and busy_count to 0, overriding regWrite and reserve in that cycle.
REQ-029 During reset, read_data1/2=0, busy1/2=0 and hazard=0 SHALL be observed from the first post-reset edge onward; reset mid-operation SHALL discard all pending reservations.

Configuration
REQ-030 Macro REGFILE_BYPASS_EN defined: when regWrite=1 and write_reg equals read_regN (not zero-register-suppressed), read_dataN SHALL return the value being written (byte-merged if byteOperations=1) in the same cycle, and REQ-027 forwarding of busyN SHALL apply.
REQ-031 REGFILE_BYPASS_EN undefined: read_dataN and busyN SHALL return pre-edge stored values; the new value is visible one cycle later.

Verification
REQ-032 Reset, then read regs 0 and 1 -> read_data1=0, read_data2=0, busy_count=0, hazard=0.
REQ-033 Write reg 2 = 0x000007F8, read reg 2 next cycle -> 0x000007F8; write reg 0 = 0xFFFFFFFF -> reg 0 reads 0.
REQ-034 Reg 3 = 0x12345678, byte write 0x000000AB -> reg 3 reads 0x123456AB.
REQ-035 Reserve reg 5 and reg 6 -> busy_count=2; read_reg1=5 -> busy1=1, hazard=1; write reg 5 -> busy1=0, busy_count=1; same-cycle reserve+write reg 6 -> busy stays 1, count stays 1.
REQ-036 Bypass: write reg 4 = 0xDEADBEEF with read_reg1=4 in same cycle -> read_data1=0xDEADBEEF that cycle with REGFILE_BYPASS_EN, old value (0) without it.
REQ-037 Reserve regs 7 and 8, assert reset together with a write to reg 7 -> all busy=0, busy_count=0, reg 7 reads 0.
